// File: rtl/led_pwm_panel.sv
// Memory-mapped LED panel: per-channel on bit, blink mask and PWM duty on the CPU6 bus.
// Optional LED_PWM_PANEL_GAMMA_EN squares the duty before comparison (gamma-corrected brightness).
module led_pwm_panel #(
  parameter logic [15:0] BASE_ADDR      = 16'hF200,
  parameter int          CHANNELS       = 8,
  parameter int          PWM_BITS       = 8,
  parameter int          BLINK_DIV_BITS = 22
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         addressBus,
  input  logic                writeEn,
  input  logic [7:0]          data_c2r,
  output logic [7:0]          data_r2c,
  output logic [CHANNELS-1:0] leds
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [BLINK_DIV_BITS-1:0] PRESC_MAX = {BLINK_DIV_BITS{1'b1}};

  logic [15:0]               addr_rel_s;
  logic                      sel_s;
  logic                      wr_s;
  logic                      rd_s;
  logic [4:0]                offset_s;
  logic [2:0]                bit_idx_s;
  logic [7:0]                rd_val_s;
  logic [7:0]                duty_rd_s;
  logic [15:0]               on_ext_s;
  logic [15:0]               blink_ext_s;
  logic [PWM_BITS-1:0]       eff_s [CHANNELS];
  logic [CHANNELS-1:0]       pwm_on_s;
`ifdef LED_PWM_PANEL_GAMMA_EN
  logic [2*PWM_BITS-1:0]     prod_s [CHANNELS];
`endif

  logic                      enable_d, enable_q;
  logic [CHANNELS-1:0]       on_d, on_q;
  logic [CHANNELS-1:0]       blink_d, blink_q;
  logic [PWM_BITS-1:0]       duty_d [CHANNELS];
  logic [PWM_BITS-1:0]       duty_q [CHANNELS];
  logic [PWM_BITS-1:0]       pwm_cnt_d, pwm_cnt_q;
  logic [BLINK_DIV_BITS-1:0] presc_d, presc_q;
  logic                      phase_d, phase_q;
  logic [CHANNELS-1:0]       leds_d, leds_q;
  logic [7:0]                rdata_d, rdata_q;

  // Address decode: window is 32 bytes starting at BASE_ADDR.
  always_comb begin
    addr_rel_s = addressBus - BASE_ADDR;
    sel_s      = (addr_rel_s < 16'd32);
    offset_s   = addressBus[4:0];
    wr_s       = sel_s & writeEn;
    rd_s       = sel_s & ~writeEn;
  end

  // Free-running PWM counter, blink prescaler and phase toggle on prescaler wrap.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    presc_d   = presc_q + BLINK_DIV_BITS'(1);
    if (presc_q == PRESC_MAX) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Register writes; bits of channels beyond CHANNELS simply have no storage.
  always_comb begin
    bit_idx_s = 3'd0;
    on_d      = on_q;
    blink_d   = blink_q;
    duty_d    = duty_q;
    if (wr_s && (offset_s == 5'h00)) begin
      enable_d = data_c2r[0];
    end else begin
      enable_d = enable_q;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      bit_idx_s = 3'(i);
      if (wr_s && (offset_s == ((i < 8) ? 5'h01 : 5'h02))) begin
        on_d[i] = data_c2r[bit_idx_s];
      end else begin
        on_d[i] = on_q[i];
      end
      if (wr_s && (offset_s == ((i < 8) ? 5'h03 : 5'h04))) begin
        blink_d[i] = data_c2r[bit_idx_s];
      end else begin
        blink_d[i] = blink_q[i];
      end
      if (wr_s && offset_s[4] && (offset_s[3:0] == 4'(i))) begin
        duty_d[i] = data_c2r[PWM_BITS-1:0];
      end else begin
        duty_d[i] = duty_q[i];
      end
    end
  end

  // Per-channel PWM compare and LED gating; all-ones duty bypasses the compare.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef LED_PWM_PANEL_GAMMA_EN
      prod_s[i] = {{PWM_BITS{1'b0}}, duty_q[i]} * {{PWM_BITS{1'b0}}, duty_q[i]};
      eff_s[i]  = PWM_BITS'(prod_s[i] >> PWM_BITS);
`else
      eff_s[i]  = duty_q[i];
`endif
      if (duty_q[i] == DUTY_MAX) begin
        pwm_on_s[i] = 1'b1;
      end else begin
        pwm_on_s[i] = (pwm_cnt_q < eff_s[i]);
      end
      leds_d[i] = enable_q & on_q[i] & (blink_q[i] ? phase_q : 1'b1) & pwm_on_s[i];
    end
  end

  // Read mux; CTRL reports the phase as it will be after this edge.
  always_comb begin
    on_ext_s    = 16'(on_q);
    blink_ext_s = 16'(blink_q);
    duty_rd_s   = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (offset_s[3:0] == 4'(i)) begin
        duty_rd_s = 8'(duty_q[i]);
      end else begin
        duty_rd_s = duty_rd_s;
      end
    end
    case (offset_s)
      5'h00:   rd_val_s = {6'b000000, phase_d, enable_q};
      5'h01:   rd_val_s = on_ext_s[7:0];
      5'h02:   rd_val_s = on_ext_s[15:8];
      5'h03:   rd_val_s = blink_ext_s[7:0];
      5'h04:   rd_val_s = blink_ext_s[15:8];
      default: rd_val_s = offset_s[4] ? duty_rd_s : 8'h00;
    endcase
    if (rd_s) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = 8'h00;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_q  <= 1'b1;
      on_q      <= {CHANNELS{1'b0}};
      blink_q   <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i] <= DUTY_MAX;
      end
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      presc_q   <= {BLINK_DIV_BITS{1'b0}};
      phase_q   <= 1'b0;
      leds_q    <= {CHANNELS{1'b0}};
      rdata_q   <= 8'h00;
    end else begin
      enable_q  <= enable_d;
      on_q      <= on_d;
      blink_q   <= blink_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      leds_q    <= leds_d;
      rdata_q   <= rdata_d;
    end
  end

  assign leds     = leds_q;
  assign data_r2c = rdata_q;

endmodule
